// File: rtl/dft_butterfly_sequencer.sv
// Address/strobe sequencer for an in-place radix-2 DIT DFT over a dual-port sample RAM.
// Issues one butterfly per cycle, delays the write-back addresses by the butterfly latency, drains between stages.
module dft_butterfly_sequencer #(
  parameter int WORD_SZ  = 8,
  parameter int N_POINTS = 8,
  parameter int LOG2N    = 3,
  parameter int BF_LAT   = 1
) (
  input  logic             i_CLK,
  input  logic             i_RESET,
  input  logic             i_start,
  output logic             o_busy,
  output logic             o_done,
  output logic [3:0]       o_stage,
  output logic             o_rd_en,
  output logic [LOG2N-1:0] o_rd_addr_a,
  output logic [LOG2N-1:0] o_rd_addr_b,
  output logic [LOG2N-2:0] o_tw_idx,
  output logic             o_wr_en,
  output logic [LOG2N-1:0] o_wr_addr_a,
  output logic [LOG2N-1:0] o_wr_addr_b
);
  localparam int D  = 1 + BF_LAT;
  localparam int KW = LOG2N - 1;
  localparam logic [KW-1:0] K_LAST = KW'(N_POINTS / 2 - 1);
  localparam logic [2:0]    D_LAST = 3'(D - 1);
  localparam logic [3:0]    S_LAST = 4'(LOG2N - 1);

  if (N_POINTS != (1 << LOG2N) || WORD_SZ < 2 || BF_LAT > 4) begin : g_bad_param
    $error("dft_butterfly_sequencer: inconsistent parameters");
  end

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  typedef struct packed {
    logic             vld;
    logic [LOG2N-1:0] a;
    logic [LOG2N-1:0] b;
  } wr_req_t;

  function automatic logic [LOG2N-1:0] half_of(input logic [3:0] s);
    return LOG2N'(1) << s;
  endfunction

  function automatic logic [LOG2N-1:0] pos_of(input logic [3:0] s, input logic [KW-1:0] k);
    return LOG2N'(k) & (half_of(s) - LOG2N'(1));
  endfunction

  // grp*2*half + pos, with grp = k >> stage
  function automatic logic [LOG2N-1:0] addr_a_of(input logic [3:0] s, input logic [KW-1:0] k);
    return ((LOG2N'(k) >> s) << (s + 4'd1)) | pos_of(s, k);
  endfunction

  function automatic logic [KW-1:0] tw_of(input logic [3:0] s, input logic [KW-1:0] k);
    logic [LOG2N-1:0] t;
    t = pos_of(s, k) << (S_LAST - s);
    return t[KW-1:0];
  endfunction

  state_t           state;
  logic [KW-1:0]    k;
  logic [2:0]       dcnt;
  logic [3:0]       nx_stage;
  logic [KW-1:0]    nx_k;
  logic [LOG2N-1:0] nx_addr_a;
  logic [LOG2N-1:0] nx_addr_b;
  wr_req_t          wr_pipe [D];

  // Butterfly that would be issued at the next edge if the FSM issues one.
  always_comb begin
    nx_stage = o_stage;
    nx_k     = k + 1'b1;
    if (state == IDLE) begin
      nx_stage = '0;
      nx_k     = '0;
    end else if (state == DRAIN) begin
      nx_stage = o_stage + 4'd1;
      nx_k     = '0;
    end
    nx_addr_a = addr_a_of(nx_stage, nx_k);
    nx_addr_b = nx_addr_a + half_of(nx_stage);
  end

  always_ff @(posedge i_CLK or negedge i_RESET) begin
    if (!i_RESET) begin
      state       <= IDLE;
      k           <= '0;
      dcnt        <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_stage     <= '0;
      o_rd_en     <= 1'b0;
      o_rd_addr_a <= '0;
      o_rd_addr_b <= '0;
      o_tw_idx    <= '0;
    end else begin
      o_done <= 1'b0;
      if (o_rd_en) o_tw_idx <= tw_of(o_stage, k);
      case (state)
        IDLE: if (i_start) begin
          state       <= READ;
          o_busy      <= 1'b1;
          o_rd_en     <= 1'b1;
          o_stage     <= nx_stage;
          k           <= nx_k;
          o_rd_addr_a <= nx_addr_a;
          o_rd_addr_b <= nx_addr_b;
        end
        READ: if (k == K_LAST) begin
          state   <= DRAIN;
          o_rd_en <= 1'b0;
          dcnt    <= '0;
        end else begin
          k           <= nx_k;
          o_rd_addr_a <= nx_addr_a;
          o_rd_addr_b <= nx_addr_b;
        end
        DRAIN: if (dcnt != D_LAST) begin
          dcnt <= dcnt + 3'd1;
        end else if (o_stage == S_LAST) begin
          state  <= DONE;
          o_busy <= 1'b0;
          o_done <= 1'b1;
        end else begin
          state       <= READ;
          o_rd_en     <= 1'b1;
          o_stage     <= nx_stage;
          k           <= nx_k;
          o_rd_addr_a <= nx_addr_a;
          o_rd_addr_b <= nx_addr_b;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write-back delay line runs regardless of FSM state so stage tails land during DRAIN.
  always_ff @(posedge i_CLK or negedge i_RESET) begin
    if (!i_RESET) begin
      for (int i = 0; i < D; i++) wr_pipe[i] <= '0;
    end else begin
      wr_pipe[0] <= '{vld: o_rd_en, a: o_rd_addr_a, b: o_rd_addr_b};
      for (int i = 1; i < D; i++) wr_pipe[i] <= wr_pipe[i-1];
    end
  end

  assign o_wr_en     = wr_pipe[D-1].vld;
  assign o_wr_addr_a = wr_pipe[D-1].a;
  assign o_wr_addr_b = wr_pipe[D-1].b;

endmodule

// File: tb/tb_dft_butterfly_sequencer.sv
// Scoreboard bench: three sequencers (BF_LAT 0/1/3) share start/reset; a model pushes the
// cycle-stamped reads, twiddles, writes and done pulse of each accepted run for a monitor to check.
`timescale 1ns/1ps
module tb_dft_butterfly_sequencer;
  localparam int N = 8, L = 3, NI = 3, HALFN = N / 2;

  typedef struct {int cyc; int a; int b; int st;} ev_t;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic busy [NI], done [NI], rd_en [NI], wr_en [NI];
  logic [3:0]   stage [NI];
  logic [L-1:0] ra [NI], rb [NI], wa [NI], wb [NI];
  logic [L-2:0] tw [NI];

  ev_t rq [NI][$];
  ev_t tq [NI][$];
  ev_t wq [NI][$];
  int  dq [NI][$];
  int  bs [NI], be [NI], nf [NI];
  int  cyc = 0, n_tests = 0, n_fail = 0;
  int  m_d, m_per, m_t, m_half, m_k;
  ev_t m_e, mon_e;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    dft_butterfly_sequencer #(.WORD_SZ(8), .N_POINTS(N), .LOG2N(L),
                              .BF_LAT((g == 0) ? 0 : (g == 1) ? 1 : 3)) u_dut (
      .i_CLK(clk), .i_RESET(rst_n), .i_start(start),
      .o_busy(busy[g]), .o_done(done[g]), .o_stage(stage[g]),
      .o_rd_en(rd_en[g]), .o_rd_addr_a(ra[g]), .o_rd_addr_b(rb[g]), .o_tw_idx(tw[g]),
      .o_wr_en(wr_en[g]), .o_wr_addr_a(wa[g]), .o_wr_addr_b(wb[g]));
  end

  function automatic int dly(input int g);
    return (g == 0) ? 1 : (g == 1) ? 2 : 4;
  endfunction

  task automatic chk(input string name, input int g, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cyc=%0d got=%0d want=%0d", name, g, cyc, act, exp);
    end
  endtask

  function automatic int all_out(input int g);
    return int'({busy[g], done[g], rd_en[g], wr_en[g], stage[g], ra[g], rb[g], wa[g], wb[g], tw[g]});
  endfunction

  // Reference model: a start seen in IDLE schedules the whole transform, built group by group.
  always @(posedge clk) begin
    cyc++;
    if (rst_n && start) begin
      for (int g = 0; g < NI; g++) begin
        if (cyc >= nf[g]) begin
          m_d = dly(g);
          m_per = HALFN + m_d;
          for (int s = 0; s < L; s++) begin
            m_half = 1 << s;
            m_k = 0;
            for (int grp = 0; grp < N / (2 * m_half); grp++)
              for (int pos = 0; pos < m_half; pos++) begin
                m_t = cyc + s * m_per + m_k;
                m_e = '{m_t, grp * 2 * m_half + pos, grp * 2 * m_half + pos + m_half, s};
                rq[g].push_back(m_e);
                m_e.cyc = m_t + m_d;
                wq[g].push_back(m_e);
                m_e = '{m_t + 1, pos * (N / (2 * m_half)), 0, s};
                tq[g].push_back(m_e);
                m_k++;
              end
          end
          bs[g] = cyc;
          be[g] = cyc + L * m_per - 1;
          dq[g].push_back(cyc + L * m_per);
          nf[g] = cyc + L * m_per + 2;
        end
      end
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (rst_n) begin
      for (int g = 0; g < NI; g++) begin
        chk("busy", g, busy[g], (cyc >= bs[g] && cyc <= be[g]) ? 1 : 0);
        if (rd_en[g]) begin
          if (rq[g].size() == 0) chk("rd_unexp", g, rd_en[g], 0);
          else begin
            mon_e = rq[g].pop_front();
            chk("rd_cyc", g, cyc, mon_e.cyc);
            chk("rd_a", g, ra[g], mon_e.a);
            chk("rd_b", g, rb[g], mon_e.b);
            chk("stage", g, stage[g], mon_e.st);
          end
        end else if (rq[g].size() > 0 && rq[g][0].cyc <= cyc) begin
          chk("rd_miss", g, rd_en[g], 1);
          void'(rq[g].pop_front());
        end
        if (tq[g].size() > 0 && tq[g][0].cyc <= cyc) begin
          mon_e = tq[g].pop_front();
          chk("tw", g, tw[g], mon_e.a);
        end
        if (wr_en[g]) begin
          if (wq[g].size() == 0) chk("wr_unexp", g, wr_en[g], 0);
          else begin
            mon_e = wq[g].pop_front();
            chk("wr_cyc", g, cyc, mon_e.cyc);
            chk("wr_a", g, wa[g], mon_e.a);
            chk("wr_b", g, wb[g], mon_e.b);
          end
        end else if (wq[g].size() > 0 && wq[g][0].cyc <= cyc) begin
          chk("wr_miss", g, wr_en[g], 1);
          void'(wq[g].pop_front());
        end
        if (done[g]) begin
          if (dq[g].size() == 0) chk("done_unexp", g, done[g], 0);
          else chk("done_cyc", g, cyc, dq[g].pop_front());
        end else if (dq[g].size() > 0 && dq[g][0] <= cyc) begin
          chk("done_miss", g, done[g], 1);
          void'(dq[g].pop_front());
        end
      end
    end
  end

  task automatic do_reset(input int ncyc);
    @(negedge clk);
    #2 rst_n = 1'b0;
    start = 1'b0;
    #1;
    for (int g = 0; g < NI; g++) begin
      chk("rst_out", g, all_out(g), 0);
      rq[g].delete(); tq[g].delete(); wq[g].delete(); dq[g].delete();
      bs[g] = 0; be[g] = -1; nf[g] = 0;
    end
    repeat (ncyc) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  int nb [NI], dc [NI], left;

  initial begin
    for (int g = 0; g < NI; g++) begin bs[g] = 0; be[g] = -1; nf[g] = 0; end
    repeat (3) @(negedge clk);
    for (int g = 0; g < NI; g++) chk("rst_out", g, all_out(g), 0);
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk); #1;
      for (int g = 0; g < NI; g++) chk("idle_out", g, all_out(g), 0);
    end

    // Single run: busy length and done cycle counted from the start edge
    pulse_start();
    for (int g = 0; g < NI; g++) begin nb[g] = 0; dc[g] = 0; end
    for (int j = 1; j <= 30; j++) begin
      if (j > 1) @(negedge clk);
      #1;
      for (int g = 0; g < NI; g++) begin
        if (busy[g]) nb[g]++;
        if (done[g] && dc[g] == 0) dc[g] = j;
      end
    end
    chk("busy_len", 0, nb[0], 15); chk("done_at", 0, dc[0], 16);
    chk("busy_len", 1, nb[1], 18); chk("done_at", 1, dc[1], 19);
    chk("busy_len", 2, nb[2], 24); chk("done_at", 2, dc[2], 25);

    // Reset during stage 1 READ, then a clean rerun
    pulse_start();
    repeat (7) @(negedge clk);
    do_reset(2);
    pulse_start();
    repeat (30) @(negedge clk);

    // Extra starts while busy, then start held high
    pulse_start();
    repeat (3) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (11) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1;
    repeat (60) @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);

    // Random start traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) do_reset($urandom_range(1, 3));
      else begin
        @(negedge clk);
        start = ($urandom_range(0, 3) == 0);
      end
    end
    start = 1'b0;

    left = 200;
    while (left > 0 && (rq[0].size() + rq[1].size() + rq[2].size() + wq[0].size() + wq[1].size() +
                        wq[2].size() + dq[0].size() + dq[1].size() + dq[2].size()) > 0) begin
      @(negedge clk);
      left--;
    end
    repeat (2) @(negedge clk);
    for (int g = 0; g < NI; g++)
      chk("pending", g, rq[g].size() + tq[g].size() + wq[g].size() + dq[g].size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dft_butterfly_sequencer.md
Name: dft_butterfly_sequencer

Overview:
- Control FSM that runs one shared butterfly_sum unit over an in-place radix-2 DIT DFT of N_POINTS complex samples held in an external dual-port sample RAM.
- Per stage it issues read-address pairs, the matching twiddle index and the delayed write-back address pairs, then drains the pipeline before starting the next stage.
- Sits between the sample loader (which writes samples in bit-reversed order) and the RAM/butterfly datapath; it has no data path of its own.

Parameters:
- WORD_SZ, 8: packed complex word width; real part in the upper half, imag in the lower half. Pass-through only; unused by the control logic.
- N_POINTS, 8: transform length; power of two, 4 to 1024.
- LOG2N, 3: log2(N_POINTS); must be consistent with N_POINTS.
- BF_LAT, 1: butterfly_sum register latency in cycles, 0 to 4.

Ports:
- i_CLK  in  1  single clock; all state updates on the rising edge.
- i_RESET  in  1  asynchronous, active-low reset.
- i_start  in  1  start request; sampled only in IDLE.
- o_busy  out  1  high from the first READ cycle through the last DRAIN cycle.
- o_done  out  1  single-cycle pulse when the transform is complete.
- o_stage  out  4  current stage, 0 to LOG2N-1.
- o_rd_en  out  1  RAM read strobe for both ports.
- o_rd_addr_a  out  LOG2N  upper-wing read address.
- o_rd_addr_b  out  LOG2N  lower-wing read address.
- o_tw_idx  out  LOG2N-1  twiddle ROM index; registered so it aligns with the RAM read data (1 cycle after o_rd_en).
- o_wr_en  out  1  RAM write-back strobe for both ports.
- o_wr_addr_a  out  LOG2N  write-back address for butterfly out1.
- o_wr_addr_b  out  LOG2N  write-back address for butterfly out2.

Behaviour:
- Reset (i_RESET=0, asynchronous): FSM goes to IDLE. All outputs are 0. Stage and butterfly counters are cleared. The write-delay pipeline is flushed, so in-flight writes are dropped. On release, the block stays in IDLE until i_start.
- States:
  - IDLE: i_start=1 at an edge moves to READ with stage=0, k=0.
  - READ: one butterfly issued per cycle.
    - half = 2^stage; pos = k & (half-1); grp = k >> stage.
    - o_rd_addr_a = grp*2*half + pos; o_rd_addr_b = o_rd_addr_a + half.
    - Twiddle index = pos << (LOG2N-1-stage).
    - o_rd_en=1. k increments each cycle. After k = N_POINTS/2-1, go to DRAIN.
  - DRAIN: D = 1+BF_LAT cycles with o_rd_en=0, o_busy=1. On exit, if stage < LOG2N-1: stage++, k=0, go to READ. Otherwise go to DONE.
  - DONE: o_done=1, o_busy=0 for one cycle, then IDLE.
- Write pipeline:
  - A D-deep shift register carries {valid, addr_a, addr_b}.
  - o_wr_en/o_wr_addr_* equal the values issued D cycles earlier.
  - It is independent of FSM state, so in-flight writes complete during DRAIN.
  - The last write of each stage lands in the last DRAIN cycle. Next-stage reads therefore never see stale data (no RAW hazard).
- Timing:
  - First o_rd_en is the cycle after the i_start edge.
  - Busy length = LOG2N*(N_POINTS/2 + D) cycles.
  - For N_POINTS=8, BF_LAT=1: 18 busy cycles, o_done in cycle 19.
- Boundary conditions:
  - i_start while busy or in DONE is ignored and is not queued.
  - i_start held high continuously restarts from IDLE after each DONE.
  - Addresses never exceed N_POINTS-1; the k counter wraps only at the stage boundary.
  - o_rd_addr_*, o_tw_idx and o_wr_addr_* hold their last values when their strobe is low. Benches check them only while the strobe is high.

Test Plan:
1. Reset then idle: i_RESET low for 3 cycles, then high with i_start=0 -> all outputs stay 0 for 20 cycles.
2. Stage-0 issue pattern (N=8, BF_LAT=1):
   - Stimulus: pulse i_start.
   - Read pairs in cycles 1-4: (0,1),(2,3),(4,5),(6,7).
   - o_tw_idx=0,0,0,0 in cycles 2-5.
   - Writes in cycles 3-6 with the same pairs.
3. Stages 1-2 issue pattern (same run):
   - Stage 1 pairs (0,2),(1,3),(4,6),(5,7), tw 0,2,0,2.
   - Stage 2 pairs (0,4),(1,5),(2,6),(3,7), tw 0,1,2,3.
   - Exactly 2 drain cycles with o_rd_en=0 before each new stage.
   - o_done high only in cycle 19.
4. Latency sweep BF_LAT=0 and BF_LAT=3:
   - Every write trails its read by exactly 1+BF_LAT cycles.
   - Busy length is 15 and 24 cycles respectively.
5. Reset mid-operation: assert i_RESET low during stage 1 READ -> outputs go to 0 immediately, no further o_wr_en, and a new i_start reproduces the scenario 2 sequence from cycle 1.
6. Start while busy: extra i_start pulses in cycles 5 and 17, then i_start held high -> the first run is unaltered, and a second run begins the cycle after DONE.
